// File: rtl/scroll_sequencer_if.sv
// scroll_sequencer_if: message ROM port between the scroll sequencer and its glyph store.
// The sequencer drives the address; the ROM answers combinationally in the same cycle.
interface scroll_sequencer_if #(
    parameter int AW = 4
);
    logic [AW-1:0] msg_addr;
    logic [6:0]    msg_seg;
    modport master (output msg_addr, input msg_seg);
    modport slave (input msg_addr, output msg_seg);
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: paces scroll steps and shifts ROM glyphs into a six-digit 7-segment window.
// Auto-steps every TICK_DIV cycles while running, or one manual step per pulse while paused.
module scroll_sequencer #(
    parameter int MSG_LEN  = 16,
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 10
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 run_toggle,
    input  logic                 step,
    input  logic                 dir,
    scroll_sequencer_if.master   rom,
    output logic [41:0]          window,
    output logic                 running,
    output logic                 shift_done,
    output logic [CNT_W-1:0]     loop_count
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [AW-1:0] HEAD_MAX = AW'(MSG_LEN - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       r_state;
    logic             r_running;
    logic [TW-1:0]    r_tick;
    logic [AW-1:0]    r_head;
    logic [41:0]      r_window;
    logic [CNT_W-1:0] r_loop;
    logic             r_done;

    logic             w_tick_term;
    logic             w_go;
    logic             w_wrap;
    logic [AW-1:0]    w_head_nxt;

    assign w_tick_term = r_running && (r_tick == TICK_MAX);
    // a toggle in the same cycle swallows a manual step; a tick terminal still fetches
    assign w_go        = (r_state == IDLE) && (w_tick_term || (!r_running && step && !run_toggle));
    assign w_wrap      = dir ? (r_head == '0) : (r_head == HEAD_MAX);
    assign w_head_nxt  = dir ? (w_wrap ? HEAD_MAX : r_head - 1'b1)
                             : (w_wrap ? '0 : r_head + 1'b1);

    assign rom.msg_addr = r_head;
    assign window       = r_window;
    assign running      = r_running;
    assign shift_done   = r_done;
    assign loop_count   = r_loop;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_tick    <= '0;
            r_head    <= '0;
            r_window  <= '1;
            r_loop    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_running <= r_running ^ run_toggle;
            r_tick    <= (run_toggle || !r_running || w_tick_term) ? '0 : r_tick + 1'b1;
            r_state   <= w_go ? FETCH : IDLE;
            r_done    <= (r_state == FETCH);
            if (r_state == FETCH) begin
                r_window <= dir ? {rom.msg_seg, r_window[41:7]} : {r_window[34:0], rom.msg_seg};
                r_head   <= w_head_nxt;
                if (w_wrap && r_loop != '1)
                    r_loop <= r_loop + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed checks of stepping, pacing, wrap, conflicts and saturation.
// Two instances: A (4 glyphs, 10-bit count) and B (2 glyphs, 2-bit count).
module tb_scroll_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;
    logic tg_a, st_a, dir_a, tg_b, st_b, dir_b;
    logic [41:0] win_a, win_b;
    logic run_a, run_b, done_a, done_b;
    logic [9:0] lc_a;
    logic [1:0] lc_b;
    int n_cmp = 0;
    int n_bad = 0;

    logic [41:0] m_win;
    logic [1:0]  m_head;
    int          m_loop;

    scroll_sequencer_if #(.AW(2)) rom_a ();
    scroll_sequencer_if #(.AW(1)) rom_b ();

    function automatic logic [6:0] rom_a_f(input logic [1:0] a);
        return (a == 2'd0) ? 7'h40 : (a == 2'd1) ? 7'h79 : (a == 2'd2) ? 7'h24 : 7'h30;
    endfunction

    assign rom_a.msg_seg = rom_a_f(rom_a.msg_addr);
    assign rom_b.msg_seg = rom_b.msg_addr ? 7'h22 : 7'h11;

    scroll_sequencer #(.MSG_LEN(4), .TICK_DIV(4), .CNT_W(10)) dut_a (
        .clock(clk), .resetb(resetb), .run_toggle(tg_a), .step(st_a), .dir(dir_a),
        .rom(rom_a), .window(win_a), .running(run_a), .shift_done(done_a), .loop_count(lc_a)
    );

    scroll_sequencer #(.MSG_LEN(2), .TICK_DIV(4), .CNT_W(2)) dut_b (
        .clock(clk), .resetb(resetb), .run_toggle(tg_b), .step(st_b), .dir(dir_b),
        .rom(rom_b), .window(win_b), .running(run_b), .shift_done(done_b), .loop_count(lc_b)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_step(input logic d);
        logic [6:0] g;
        g = rom_a_f(m_head);
        m_win = d ? {g, m_win[41:7]} : {m_win[34:0], g};
        if (d) begin
            if (m_head == 2'd0) begin m_head = 2'd3; m_loop++; end
            else m_head--;
        end else begin
            if (m_head == 2'd3) begin m_head = 2'd0; m_loop++; end
            else m_head++;
        end
    endtask

    task automatic do_reset;
        resetb = 1'b0;
        cyc(2);
        resetb = 1'b1;
        cyc(1);
        m_win = '1;
        m_head = 2'd0;
        m_loop = 0;
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        cyc(3);
        n_cmp++; if (win_a !== 42'h3FF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_win: got %h want 3ffffffffff", win_a); end
        n_cmp++; if (run_a !== 1'b0) begin n_bad++; $display("FAIL reset_run: got %b want 0", run_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (lc_a !== 10'd0) begin n_bad++; $display("FAIL reset_loop: got %0d want 0", lc_a); end
        n_cmp++; if (rom_a.msg_addr !== 2'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", rom_a.msg_addr); end
        n_cmp++; if (lc_b !== 2'd0) begin n_bad++; $display("FAIL reset_loop_b: got %0d want 0", lc_b); end
        resetb = 1'b1;
        cyc(1);
        m_win = '1;
        m_head = 2'd0;
        m_loop = 0;
    endtask

    task automatic test_manual_step;
        int pulses;
        pulses = 0;
        dir_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st_a = 1'b1;
            cyc(1);
            st_a = 1'b0;
            n_cmp++; if (rom_a.msg_addr !== 2'(k)) begin n_bad++; $display("FAIL manual_addr%0d: got %0d want %0d", k, rom_a.msg_addr, k); end
            model_step(1'b0);
            cyc(1);
            if (done_a === 1'b1) pulses++;
            n_cmp++; if (win_a !== m_win) begin n_bad++; $display("FAIL manual_win%0d: got %h want %h", k, win_a, m_win); end
            cyc(1);
            n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL manual_done_low%0d: got %b want 0", k, done_a); end
            cyc(2);
        end
        n_cmp++; if (win_a[27:0] !== {7'h40, 7'h79, 7'h24, 7'h30}) begin n_bad++; $display("FAIL manual_low4: got %h want %h", win_a[27:0], {7'h40, 7'h79, 7'h24, 7'h30}); end
        n_cmp++; if (win_a[41:28] !== 14'h3FFF) begin n_bad++; $display("FAIL manual_high2: got %h want 3fff", win_a[41:28]); end
        n_cmp++; if (lc_a !== 10'd1) begin n_bad++; $display("FAIL manual_loop: got %0d want 1", lc_a); end
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL manual_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_auto_pacing;
        logic exp_done;
        int bad_quiet;
        logic [41:0] held;
        dir_a = 1'b0;
        tg_a = 1'b1;
        cyc(1);
        tg_a = 1'b0;
        n_cmp++; if (run_a !== 1'b1) begin n_bad++; $display("FAIL auto_run_on: got %b want 1", run_a); end
        for (int i = 1; i <= 14; i++) begin
            cyc(1);
            exp_done = (i == 5) || (i == 9) || (i == 13);
            if (exp_done) model_step(1'b0);
            n_cmp++; if (done_a !== exp_done) begin n_bad++; $display("FAIL auto_done_c%0d: got %b want %b", i, done_a, exp_done); end
            if (exp_done) begin
                n_cmp++; if (win_a !== m_win) begin n_bad++; $display("FAIL auto_win_c%0d: got %h want %h", i, win_a, m_win); end
            end
        end
        tg_a = 1'b1;
        cyc(1);
        tg_a = 1'b0;
        n_cmp++; if (run_a !== 1'b0) begin n_bad++; $display("FAIL auto_run_off: got %b want 0", run_a); end
        held = win_a;
        bad_quiet = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (done_a !== 1'b0 || win_a !== held) bad_quiet++;
        end
        n_cmp++; if (bad_quiet !== 0) begin n_bad++; $display("FAIL auto_quiet: got %0d active cycles want 0", bad_quiet); end
        n_cmp++; if (lc_a !== 10'(m_loop)) begin n_bad++; $display("FAIL auto_loop: got %0d want %0d", lc_a, m_loop); end
    endtask

    task automatic test_right_wrap;
        logic [1:0] ea [5];
        int el [5];
        ea = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        el = '{1, 1, 1, 1, 2};
        do_reset();
        dir_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            st_a = 1'b1;
            cyc(1);
            st_a = 1'b0;
            n_cmp++; if (rom_a.msg_addr !== ea[k]) begin n_bad++; $display("FAIL right_addr%0d: got %0d want %0d", k, rom_a.msg_addr, ea[k]); end
            model_step(1'b1);
            cyc(1);
            n_cmp++; if (win_a[41:35] !== rom_a_f(ea[k])) begin n_bad++; $display("FAIL right_hex5_%0d: got %h want %h", k, win_a[41:35], rom_a_f(ea[k])); end
            n_cmp++; if (win_a !== m_win) begin n_bad++; $display("FAIL right_win%0d: got %h want %h", k, win_a, m_win); end
            n_cmp++; if (lc_a !== 10'(el[k])) begin n_bad++; $display("FAIL right_loop%0d: got %0d want %0d", k, lc_a, el[k]); end
            cyc(2);
        end
        dir_a = 1'b0;
    endtask

    task automatic test_conflicts;
        do_reset();
        dir_a = 1'b0;
        tg_a = 1'b1;
        st_a = 1'b1;
        cyc(1);
        tg_a = 1'b0;
        st_a = 1'b0;
        n_cmp++; if (run_a !== 1'b1) begin n_bad++; $display("FAIL conf_run: got %b want 1", run_a); end
        cyc(1);
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL conf_toggle_step: got %b want 0", done_a); end
        st_a = 1'b1;
        cyc(1);
        st_a = 1'b0;
        cyc(1);
        n_cmp++; if (done_a !== 1'b0 || win_a !== m_win) begin n_bad++; $display("FAIL conf_step_running: got done=%b win=%h want done=0 win=%h", done_a, win_a, m_win); end
        tg_a = 1'b1;
        cyc(1);
        tg_a = 1'b0;
        n_cmp++; if (run_a !== 1'b0) begin n_bad++; $display("FAIL conf_pause_tick_run: got %b want 0", run_a); end
        model_step(1'b0);
        cyc(1);
        n_cmp++; if (done_a !== 1'b1 || win_a !== m_win) begin n_bad++; $display("FAIL conf_pause_tick_fetch: got done=%b win=%h want done=1 win=%h", done_a, win_a, m_win); end
        st_a = 1'b1;
        cyc(2);
        st_a = 1'b0;
        model_step(1'b0);
        n_cmp++; if (done_a !== 1'b1 || win_a !== m_win) begin n_bad++; $display("FAIL conf_step_fetch1: got done=%b win=%h want done=1 win=%h", done_a, win_a, m_win); end
        cyc(1);
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL conf_step_in_fetch: got %b want 0", done_a); end
        cyc(1);
        n_cmp++; if (win_a !== m_win || done_a !== 1'b0) begin n_bad++; $display("FAIL conf_no_queue: got done=%b win=%h want done=0 win=%h", done_a, win_a, m_win); end
    endtask

    task automatic test_saturation;
        int el [10];
        el = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
        dir_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            st_b = 1'b1;
            cyc(1);
            st_b = 1'b0;
            cyc(1);
            n_cmp++; if (win_b[6:0] !== ((k % 2) ? 7'h11 : 7'h22)) begin n_bad++; $display("FAIL sat_hex0_%0d: got %h want %h", k, win_b[6:0], (k % 2) ? 7'h11 : 7'h22); end
            n_cmp++; if (lc_b !== 2'(el[k-1])) begin n_bad++; $display("FAIL sat_loop%0d: got %0d want %0d", k, lc_b, el[k-1]); end
            cyc(1);
        end
        n_cmp++; if (win_b[13:7] !== 7'h11) begin n_bad++; $display("FAIL sat_hex1: got %h want 11", win_b[13:7]); end
    endtask

    task automatic test_reset_midrun;
        tg_a = 1'b1;
        cyc(1);
        tg_a = 1'b0;
        cyc(4);
        #3;
        resetb = 1'b0;
        #1;
        n_cmp++; if (win_a !== 42'h3FF_FFFF_FFFF) begin n_bad++; $display("FAIL midrun_win: got %h want 3ffffffffff", win_a); end
        n_cmp++; if (run_a !== 1'b0 || lc_a !== 10'd0 || done_a !== 1'b0) begin n_bad++; $display("FAIL midrun_ctl: got run=%b loop=%0d done=%b want 0/0/0", run_a, lc_a, done_a); end
        cyc(1);
        n_cmp++; if (done_a !== 1'b0 || win_a !== 42'h3FF_FFFF_FFFF) begin n_bad++; $display("FAIL midrun_abort: got done=%b win=%h want done=0 win=3ffffffffff", done_a, win_a); end
        resetb = 1'b1;
        cyc(1);
    endtask

    initial begin
        resetb = 1'b0;
        {tg_a, st_a, dir_a, tg_b, st_b, dir_b} = '0;
        test_reset();
        test_manual_step();
        test_auto_pacing();
        test_right_wrap();
        test_conflicts();
        test_saturation();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
